// File: rtl/key_pkg.sv
// Shared types and default timing for the multi-channel key conditioner.
package key_pkg;

  // Hold tracker states for one key channel
  typedef enum logic [1:0] {
    RELEASED = 2'd0,
    HELD     = 2'd1,
    REPEAT   = 2'd2
  } hold_state_t;

  // Default timing in clk cycles
  localparam int DEF_DEBOUNCE_CYCLES = 240_000;
  localparam int DEF_LONG_CYCLES     = 12_000_000;
  localparam int DEF_REPEAT_CYCLES   = 2_400_000;

  // Width of a counter that must hold values 0 .. n-1
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/key_channel.sv
// One key channel: 2-flop synchroniser, debounce filter, press/release pulses
// and the hold tracker that produces long-press and auto-repeat pulses.
module key_channel
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int LONG_CYCLES     = DEF_LONG_CYCLES,
  parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES,
  parameter bit REPEAT_EN       = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic key,
  output logic key_state,
  output logic key_press,
  output logic key_release,
  output logic key_long,
  output logic key_repeat
);

  localparam int DB_W     = cnt_width(DEBOUNCE_CYCLES);
  localparam int HOLD_MAX = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
  localparam int HOLD_W   = cnt_width(HOLD_MAX);

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] LONG_LAST = HOLD_W'(LONG_CYCLES - 1);
  localparam logic [HOLD_W-1:0] REP_LAST  = HOLD_W'(REPEAT_CYCLES - 1);

  logic              key_p0;
  logic              key_p1;
  logic              s;
  logic              differ;
  logic              accept;
  logic              acc_press;
  logic              acc_release;
  logic [DB_W-1:0]   db_cnt;

  hold_state_t       state_q;
  hold_state_t       state_d;
  logic [HOLD_W-1:0] hold_cnt;
  logic [HOLD_W-1:0] hold_cnt_d;
  logic              long_d;
  logic              repeat_d;

  // Synchroniser: pins idle high, so both flops reset to the released level
  always_ff @(posedge clk) begin
    if (!rst) begin
      key_p0 <= 1'b1;
      key_p1 <= 1'b1;
    end else begin
      key_p0 <= key;
      key_p1 <= key_p0;
    end
  end

  // Pins are active-low; everything past the synchroniser is active-high
  assign s           = ~key_p1;
  assign differ      = (s != key_state);
  assign accept      = differ && (db_cnt == DB_LAST);
  assign acc_press   = accept &&  s;
  assign acc_release = accept && !s;

  // Debounce filter: any sample matching the current level restarts the window
  always_ff @(posedge clk) begin
    if (!rst) begin
      db_cnt      <= '0;
      key_state   <= 1'b0;
      key_press   <= 1'b0;
      key_release <= 1'b0;
    end else begin
      if (!differ || accept) begin
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + DB_W'(1);
      end
      if (accept) begin
        key_state <= s;
      end
      key_press   <= acc_press;
      key_release <= acc_release;
    end
  end

  // Hold tracker state register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= RELEASED;
    end else begin
      state_q <= state_d;
    end
  end

  // Hold tracker next state; a release always wins over long/repeat
  always_comb begin
    state_d = state_q;
    case (state_q)
      RELEASED: if (acc_press) state_d = HELD;
      HELD: begin
        if (acc_release) begin
          state_d = RELEASED;
        end else if (hold_cnt == LONG_LAST) begin
          state_d = REPEAT;
        end
      end
      REPEAT:   if (acc_release) state_d = RELEASED;
      default:  state_d = RELEASED;
    endcase
  end

  // Hold tracker outputs: counter update and long/repeat pulse requests
  always_comb begin
    hold_cnt_d = '0;
    long_d     = 1'b0;
    repeat_d   = 1'b0;
    case (state_q)
      HELD: begin
        if (!acc_release) begin
          if (hold_cnt == LONG_LAST) begin
            long_d = 1'b1;
          end else begin
            hold_cnt_d = hold_cnt + HOLD_W'(1);
          end
        end
      end
      REPEAT: begin
        if (!acc_release && REPEAT_EN) begin
          if (hold_cnt == REP_LAST) begin
            repeat_d = 1'b1;
          end else begin
            hold_cnt_d = hold_cnt + HOLD_W'(1);
          end
        end
      end
      default: hold_cnt_d = '0;
    endcase
  end

  // Registered hold counter and long/repeat pulses
  always_ff @(posedge clk) begin
    if (!rst) begin
      hold_cnt   <= '0;
      key_long   <= 1'b0;
      key_repeat <= 1'b0;
    end else begin
      hold_cnt   <= hold_cnt_d;
      key_long   <= long_d;
      key_repeat <= repeat_d;
    end
  end

endmodule

// File: rtl/key_debounce_multi.sv
// N-channel push-button conditioner between active-low key pins and the
// code-lock control logic. Channels are independent copies of key_channel.
module key_debounce_multi
  import key_pkg::*;
#(
  parameter int N               = 2,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int LONG_CYCLES     = DEF_LONG_CYCLES,
  parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES,
  parameter bit REPEAT_EN       = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] key,
  output logic [N-1:0] key_state,
  output logic [N-1:0] key_press,
  output logic [N-1:0] key_release,
  output logic [N-1:0] key_long,
  output logic [N-1:0] key_repeat
);

  for (genvar i = 0; i < N; i++) begin : g_ch
    key_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .LONG_CYCLES     (LONG_CYCLES),
      .REPEAT_CYCLES   (REPEAT_CYCLES),
      .REPEAT_EN       (REPEAT_EN)
    ) u_ch (
      .clk         (clk),
      .rst         (rst),
      .key         (key[i]),
      .key_state   (key_state[i]),
      .key_press   (key_press[i]),
      .key_release (key_release[i]),
      .key_long    (key_long[i]),
      .key_repeat  (key_repeat[i])
    );
  end

endmodule

// File: tb/tb_key_debounce_multi.sv
// Directed bench for key_debounce_multi with short timing (debounce 4,
// long 10, repeat 3). A second instance with auto-repeat disabled shares
// the same stimulus.
module tb_key_debounce_multi;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] key;

  logic [1:0] key_state, key_press, key_release, key_long, key_repeat;
  logic [1:0] nr_state, nr_press, nr_release, nr_long, nr_repeat;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  key_debounce_multi #(
    .N(2), .DEBOUNCE_CYCLES(4), .LONG_CYCLES(10), .REPEAT_CYCLES(3), .REPEAT_EN(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .key(key),
    .key_state(key_state), .key_press(key_press), .key_release(key_release),
    .key_long(key_long), .key_repeat(key_repeat)
  );

  key_debounce_multi #(
    .N(2), .DEBOUNCE_CYCLES(4), .LONG_CYCLES(10), .REPEAT_CYCLES(3), .REPEAT_EN(1'b0)
  ) dut_nr (
    .clk(clk), .rst(rst), .key(key),
    .key_state(nr_state), .key_press(nr_press), .key_release(nr_release),
    .key_long(nr_long), .key_repeat(nr_repeat)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [1:0] got, input logic [1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [1:0] st, input logic [1:0] pr,
                         input logic [1:0] rl, input logic [1:0] lg, input logic [1:0] rp);
    chk({tag, " state"},      key_state,   st);
    chk({tag, " press"},      key_press,   pr);
    chk({tag, " release"},    key_release, rl);
    chk({tag, " long"},       key_long,    lg);
    chk({tag, " repeat"},     key_repeat,  rp);
    chk({tag, " nr_state"},   nr_state,    st);
    chk({tag, " nr_press"},   nr_press,    pr);
    chk({tag, " nr_release"}, nr_release,  rl);
    chk({tag, " nr_long"},    nr_long,     lg);
    chk({tag, " nr_repeat"},  nr_repeat,   2'b00);
  endtask

  initial begin
    // Reset with keys held, then release reset with keys up
    rst = 1'b0;
    key = 2'b00;
    step();
    step();
    chk_all("reset", 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    rst = 1'b1;
    key = 2'b11;
    for (int k = 1; k <= 8; k++) begin
      step();
      chk_all($sformatf("idle k=%0d", k), 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    end

    // Clean press on key[0], held through long press and repeats
    key = 2'b10;
    for (int k = 1; k <= 22; k++) begin
      step();
      chk_all($sformatf("hold k=%0d", k), {1'b0, k >= 6}, {1'b0, k == 6}, 2'b00,
              {1'b0, k == 16}, {1'b0, (k == 19) || (k == 22)});
    end
    // Release: one more repeat at 25, release at 28 suppresses the repeat due then
    key = 2'b11;
    for (int k = 23; k <= 32; k++) begin
      step();
      chk_all($sformatf("rel k=%0d", k), {1'b0, k < 28}, 2'b00, {1'b0, k == 28},
              2'b00, {1'b0, k == 25});
    end

    // Bouncing press (0,1,0,1 then steady 0), then release landing on the long edge
    for (int k = 1; k <= 22; k++) begin
      key = {1'b1, (k == 2) || (k == 4) || (k >= 15)};
      step();
      chk_all($sformatf("bounce k=%0d", k), {1'b0, (k >= 10) && (k < 20)},
              {1'b0, k == 10}, {1'b0, k == 20}, 2'b00, 2'b00);
    end

    // Both keys pressed on the same edge
    key = 2'b00;
    for (int k = 1; k <= 8; k++) begin
      step();
      chk_all($sformatf("both k=%0d", k), (k >= 6) ? 2'b11 : 2'b00,
              (k == 6) ? 2'b11 : 2'b00, 2'b00, 2'b00, 2'b00);
    end
    // Reset while held: outputs clear, no release pulse afterwards
    rst = 1'b0;
    step();
    chk_all("midrst 1", 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    step();
    chk_all("midrst 2", 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    rst = 1'b1;
    key = 2'b11;
    for (int k = 1; k <= 8; k++) begin
      step();
      chk_all($sformatf("postrst k=%0d", k), 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
